pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game-flow sequencer for the Pong pixel datapath. Holds, centres and serves the ball,
//  detects points from datapath miss flags, keeps both scores and declares a winner.
//  Runs on the pixel clock and advances timing on the once-per-frame refresh tick.
//  Drives the ball hold/centre/direction controls of the pixel generator.
// PARAMETERS
//  WIN_SCORE     7   points needed to win, range 1..15
//  SERVE_FRAMES  60  frame ticks the ball is held at centre before a serve, >=1
//  POINT_FRAMES  90  frame ticks of pause after a point, >=1
//  RALLY_HITS    4   paddle hits per speed step (PONG_SPEEDUP_EN only)
//  MAX_SPEED     3   maximum speed_level (PONG_SPEEDUP_EN only)
// PORTS
//  clk          in   1  pixel clock
//  reset        in   1  asynchronous, active-high; one clock domain
//  frame_tick   in   1  one-cycle pulse per frame (start of vertical retrace)
//  start        in   1  level, debounced start button
//  miss_left    in   1  ball passed the left boundary (player 2 scores)
//  miss_right   in   1  ball passed the right boundary (player 1 scores)
//  paddle_hit   in   1  one-cycle pulse when the ball bounces off either paddle
//  ball_hold    out  1  1 = datapath freezes the ball
//  ball_center  out  1  one-cycle pulse: datapath loads the ball at screen centre
//  serve_dir    out  1  0 = serve toward the right, 1 = serve toward the left
//  score1       out  4  player 1 score
//  score2       out  4  player 2 score
//  game_over    out  1  high while in GAMEOVER
//  winner       out  1  0 = player 1, 1 = player 2; valid while game_over=1
//  speed_level  out  2  ball speed step, 0 = base speed
//  state        out  3  IDLE=0 SERVE=1 PLAY=2 POINT=3 GAMEOVER=4
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, ball_hold=1, ball_center=0, serve_dir=0,
//    scores=0, game_over=0, winner=0, speed_level=0, frame counter=0. Reset mid-game aborts immediately.
//  - IDLE: ball_hold=1. start=1 -> SERVE next cycle.
//  - SERVE: ball_center pulses in the first SERVE cycle only; ball_hold=1; counter clears on entry
//    and increments on each frame_tick; on the SERVE_FRAMES-th tick -> PLAY.
//  - PLAY: ball_hold=0. miss_left -> score2+1, serve_dir=1, -> POINT. miss_right -> score1+1,
//    serve_dir=0, -> POINT. Both in the same cycle: miss_left wins; miss_right is dropped.
//    Only the first cycle of a miss is counted (a flag held high scores once).
//  - POINT: ball_hold=1; after POINT_FRAMES frame ticks -> GAMEOVER if either score == WIN_SCORE,
//    else -> SERVE.
//  - GAMEOVER: game_over=1, winner set on entry, scores frozen; start=1 clears scores and
//    speed_level, -> SERVE.
//  - start is ignored in SERVE, PLAY and POINT; miss/paddle inputs are ignored outside PLAY.
//  - Scores never exceed WIN_SCORE; no wrap. Latency of input to output is 1 clk.
//  - frame_tick in the same cycle as a state entry is counted by the new state's counter.
// CONFIGURATION
//  PONG_SPEEDUP_EN defined: 3-bit rally counter counts paddle_hit in PLAY; on reaching
//    RALLY_HITS it clears and speed_level increments, saturating at MAX_SPEED.
//    Rally counter and speed_level clear on entry to POINT.
//  PONG_SPEEDUP_EN undefined: no rally counter, speed_level tied to 0, paddle_hit unused.
// TESTING (bench parameters SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=2)
//  - reset, start=1 for 1 clk -> state=1, ball_center one pulse, 3 frame_ticks later state=2, ball_hold=0.
//  - PLAY, miss_right held 5 clk -> score1=1 (once), serve_dir=0, state=3; 2 ticks -> state=1.
//  - PLAY, miss_left and miss_right same clk -> score2+1 only, serve_dir=1.
//  - Player 2 reaches 2 -> after POINT pause state=4, game_over=1, winner=1; start -> scores 0, state=1.
//  - reset asserted mid-PLAY with score1=1 -> same-cycle IDLE, all outputs at reset values.
//  - PONG_SPEEDUP_EN, RALLY_HITS=4: 12 paddle_hit pulses -> speed_level 3 (saturated); a miss -> 0.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl -- game-flow sequencer for the Pong pixel datapath.
// Holds, centres and serves the ball, turns datapath miss flags into points,
// keeps both scores and declares a winner. Timing advances on frame_tick.
// Optional feature macro: PONG_SPEEDUP_EN (rally counter and ball speed steps).
// Without the macro speed_level is tied to 0 and paddle_hit is unused.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int RALLY_HITS   = 4,
    parameter int MAX_SPEED    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic       ball_hold,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] speed_level,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SERVE    = 3'd1;
    localparam logic [2:0] S_PLAY     = 3'd2;
    localparam logic [2:0] S_POINT    = 3'd3;
    localparam logic [2:0] S_GAMEOVER = 3'd4;

    // One frame counter is shared by SERVE and POINT; it only needs to reach
    // the larger of the two pause lengths minus one.
    localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    logic [2:0]       state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       score1_n, score2_n;
    logic             dir_n, winner_n;
    logic             miss_left_q, miss_right_q;
    logic             miss_left_rise, miss_right_rise;

`ifdef PONG_SPEEDUP_EN
    logic [2:0] rally_q, rally_n;
    logic [1:0] speed_n;
    localparam logic [2:0] RALLY_LAST = 3'(RALLY_HITS - 1);
    localparam logic [1:0] SPEED_TOP  = 2'(MAX_SPEED);
`else
    logic unused_speedup;
    assign unused_speedup = paddle_hit ^ (RALLY_HITS == 0) ^ (MAX_SPEED == 0);
    assign speed_level    = 2'd0;
`endif

    // A miss flag may stay high for many cycles; only its rising edge scores.
    assign miss_left_rise  = miss_left & ~miss_left_q;
    assign miss_right_rise = miss_right & ~miss_right_q;

    // Next-state, counter and score logic for the game flow.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt_q;
        score1_n = score1;
        score2_n = score2;
        dir_n    = serve_dir;
        winner_n = winner;
`ifdef PONG_SPEEDUP_EN
        rally_n  = rally_q;
        speed_n  = speed_level;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SERVE;
                    cnt_n   = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_n = S_PLAY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                // miss_left has priority; a simultaneous miss_right is dropped.
                if (miss_left_rise || miss_right_rise) begin
                    if (miss_left_rise) begin
                        if (score2 != WIN) score2_n = score2 + 4'd1;
                        dir_n = 1'b1;
                    end else begin
                        if (score1 != WIN) score1_n = score1 + 4'd1;
                        dir_n = 1'b0;
                    end
                    state_n = S_POINT;
                    cnt_n   = '0;
`ifdef PONG_SPEEDUP_EN
                    rally_n = '0;
                    speed_n = '0;
`endif
                end
`ifdef PONG_SPEEDUP_EN
                else if (paddle_hit) begin
                    if (rally_q == RALLY_LAST) begin
                        rally_n = '0;
                        if (speed_level != SPEED_TOP) speed_n = speed_level + 2'd1;
                    end else begin
                        rally_n = rally_q + 3'd1;
                    end
                end
`endif
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        cnt_n = '0;
                        if (score1 == WIN || score2 == WIN) begin
                            state_n  = S_GAMEOVER;
                            winner_n = (score2 == WIN);
                        end else begin
                            state_n = S_SERVE;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            S_GAMEOVER: begin
                if (start) begin
                    state_n  = S_SERVE;
                    cnt_n    = '0;
                    score1_n = '0;
                    score2_n = '0;
`ifdef PONG_SPEEDUP_EN
                    rally_n  = '0;
                    speed_n  = '0;
`endif
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State and registered outputs; outputs are derived from the next state so
    // they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt_q        <= '0;
            score1       <= '0;
            score2       <= '0;
            serve_dir    <= 1'b0;
            winner       <= 1'b0;
            ball_hold    <= 1'b1;
            ball_center  <= 1'b0;
            game_over    <= 1'b0;
            miss_left_q  <= 1'b0;
            miss_right_q <= 1'b0;
        end else begin
            state        <= state_n;
            cnt_q        <= cnt_n;
            score1       <= score1_n;
            score2       <= score2_n;
            serve_dir    <= dir_n;
            winner       <= winner_n;
            ball_hold    <= (state_n != S_PLAY);
            ball_center  <= (state_n == S_SERVE) && (state != S_SERVE);
            game_over    <= (state_n == S_GAMEOVER);
            miss_left_q  <= miss_left;
            miss_right_q <= miss_right;
        end
    end

`ifdef PONG_SPEEDUP_EN
    // Rally counter and speed step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rally_q     <= '0;
            speed_level <= '0;
        end else begin
            rally_q     <= rally_n;
            speed_level <= speed_n;
        end
    end
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: directed game scenarios followed by random
// stimulus, all checked against a rule-level game model through a queue.
module tb_pong_game_ctrl;

    localparam int WIN = 2;
    localparam int SF  = 3;
    localparam int PF  = 2;
    localparam int RH  = 4;
    localparam int MS  = 3;
`ifdef PONG_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       paddle_hit = 1'b0;
    logic       ball_hold, ball_center, serve_dir, game_over, winner;
    logic [3:0] score1, score2;
    logic [1:0] speed_level;
    logic [2:0] state;
    logic [17:0] dut_vec;

    int checks = 0;
    int failures = 0;
    logic [17:0] exp_q[$];

    // Game model (rule level)
    int m_state, m_ticks, m_s1, m_s2, m_speed, m_hits;
    bit m_dir, m_win, m_pml, m_pmr;

    pong_game_ctrl #(
        .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF),
        .RALLY_HITS(RH), .MAX_SPEED(MS)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .miss_left(miss_left), .miss_right(miss_right), .paddle_hit(paddle_hit),
        .ball_hold(ball_hold), .ball_center(ball_center), .serve_dir(serve_dir),
        .score1(score1), .score2(score2), .game_over(game_over), .winner(winner),
        .speed_level(speed_level), .state(state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    assign dut_vec = {ball_hold, ball_center, serve_dir, score1, score2,
                      game_over, winner, speed_level, state};

    function automatic logic [17:0] pack(input bit hold, input bit center, input bit dir,
                                         input logic [3:0] s1, input logic [3:0] s2,
                                         input bit over, input bit win,
                                         input logic [1:0] spd, input logic [2:0] st);
        return {hold, center, dir, s1, s2, over, win, spd, st};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_speed = 0; m_hits = 0;
        m_dir = 0; m_win = 0; m_pml = 0; m_pmr = 0;
    endtask

    // Advance the model by one clock edge with the given inputs and queue the
    // outputs the DUT must show after that edge.
    task automatic model_step(input bit st, input bit tk, input bit ml, input bit mr, input bit ph);
        bit ml_new, mr_new;
        int prev;
        ml_new = ml && !m_pml;
        mr_new = mr && !m_pmr;
        m_pml = ml;
        m_pmr = mr;
        prev = m_state;
        case (m_state)
            0: if (st) begin m_state = 1; m_ticks = 0; end
            1: if (tk) begin
                   m_ticks++;
                   if (m_ticks == SF) begin m_state = 2; m_ticks = 0; end
               end
            2: if (ml_new || mr_new) begin
                   if (ml_new) begin
                       if (m_s2 < WIN) m_s2++;
                       m_dir = 1;
                   end else begin
                       if (m_s1 < WIN) m_s1++;
                       m_dir = 0;
                   end
                   m_state = 3; m_ticks = 0; m_hits = 0; m_speed = 0;
               end else if (ph) begin
                   m_hits++;
                   if (m_hits == RH) begin
                       m_hits = 0;
                       if (SPEEDUP && m_speed < MS) m_speed++;
                   end
               end
            3: if (tk) begin
                   m_ticks++;
                   if (m_ticks == PF) begin
                       m_ticks = 0;
                       if (m_s1 == WIN || m_s2 == WIN) begin
                           m_state = 4;
                           m_win = (m_s2 == WIN);
                       end else begin
                           m_state = 1;
                       end
                   end
               end
            default: if (st) begin
                   m_s1 = 0; m_s2 = 0; m_speed = 0; m_hits = 0;
                   m_state = 1; m_ticks = 0;
               end
        endcase
        exp_q.push_back(pack(m_state != 2, (m_state == 1) && (prev != 1), m_dir,
                             4'(m_s1), 4'(m_s2), m_state == 4, m_win,
                             2'(m_speed), 3'(m_state)));
    endtask

    // Driver: one clock of stimulus, applied on the falling edge
    task automatic cyc(input bit st, input bit tk, input bit ml, input bit mr, input bit ph);
        @(negedge clk);
        start = st; frame_tick = tk; miss_left = ml; miss_right = mr; paddle_hit = ph;
        model_step(st, tk, ml, mr, ph);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample just after the edge that consumed the last driven cycle
    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Asynchronous reset: outputs must be at reset values within the same cycle
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        start = 0; frame_tick = 0; miss_left = 0; miss_right = 0; paddle_hit = 0;
        #1;
        check("async_reset_outputs", 32'(dut_vec), 32'(pack(1, 0, 0, 4'd0, 4'd0, 0, 0, 2'd0, 3'd0)));
        model_reset();
        repeat (n) @(negedge clk);
        reset = 1'b0;
        model_step(0, 0, 0, 0, 0);
    endtask

    // Scoreboard monitor
    initial begin
        logic [17:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dut_vec !== e) begin
                    failures++;
                    $display("FAIL scoreboard: got %05h expected %05h (hold,center,dir,s1,s2,over,win,spd,state) at %0t",
                             dut_vec, e, $time);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit st, tk, ml, mr, ph;
        int ml_hold, mr_hold;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'(dut_vec), 32'(pack(1, 0, 0, 4'd0, 4'd0, 0, 0, 2'd0, 3'd0)));
        @(negedge clk);
        reset = 1'b0;
        model_step(0, 0, 0, 0, 0);

        // Start and serve
        cyc(1, 0, 0, 0, 0);
        settle();
        check("serve_state", 32'(state), 1);
        check("center_pulse", 32'(ball_center), 1);
        cyc(0, 0, 0, 0, 0);
        settle();
        check("center_once", 32'(ball_center), 0);
        check("hold_in_serve", 32'(ball_hold), 1);
        ticks(2);
        settle();
        check("serve_before_last_tick", 32'(state), 1);
        ticks(1);
        settle();
        check("play_state", 32'(state), 2);
        check("play_hold", 32'(ball_hold), 0);

        // Held miss_right scores once
        cyc(0, 0, 0, 1, 0);
        settle();
        check("miss_right_score1", 32'(score1), 1);
        check("miss_right_dir", 32'(serve_dir), 0);
        check("point_state", 32'(state), 3);
        repeat (4) cyc(0, 0, 0, 1, 0);
        settle();
        check("held_miss_once", 32'(score1), 1);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        settle();
        check("point_to_serve", 32'(state), 1);
        ticks(SF);

        // Simultaneous misses: left wins
        cyc(0, 0, 1, 1, 0);
        settle();
        check("both_miss_score2", 32'(score2), 1);
        check("both_miss_score1", 32'(score1), 1);
        check("both_miss_dir", 32'(serve_dir), 1);
        ticks(PF);
        ticks(SF);

        // Rally speed-up and saturation
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0);
        end
        settle();
        check("speed_saturated", 32'(speed_level), SPEEDUP ? MS : 0);
        cyc(0, 0, 0, 1, 0);
        settle();
        check("speed_cleared_on_point", 32'(speed_level), 0);
        check("score1_at_win", 32'(score1), 2);
        ticks(PF);
        settle();
        check("gameover_state", 32'(state), 4);
        check("game_over_flag", 32'(game_over), 1);
        check("winner_p1", 32'(winner), 0);
        cyc(0, 0, 1, 0, 0);
        settle();
        check("miss_ignored_gameover", 32'(score2), 1);
        cyc(1, 0, 0, 0, 0);
        settle();
        check("restart_state", 32'(state), 1);
        check("restart_score1", 32'(score1), 0);
        check("restart_score2", 32'(score2), 0);
        ticks(SF);

        // Player 2 wins
        for (int p = 0; p < 2; p++) begin
            cyc(0, 0, 1, 0, 0);
            ticks(PF);
            if (p == 0) ticks(SF);
        end
        settle();
        check("p2_gameover", 32'(state), 4);
        check("p2_winner", 32'(winner), 1);
        cyc(1, 0, 0, 0, 0);
        ticks(SF);

        // Reset mid-PLAY with score1 = 1
        cyc(0, 0, 0, 1, 0);
        ticks(PF);
        ticks(SF);
        settle();
        check("pre_reset_play", 32'(state), 2);
        check("pre_reset_score1", 32'(score1), 1);
        do_reset(2);

        // Random play
        ml_hold = 0;
        mr_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 750 == 749) begin
                do_reset(2);
                ml_hold = 0;
                mr_hold = 0;
            end else begin
                st = ($urandom_range(0, 15) == 0);
                tk = ($urandom_range(0, 2) == 0);
                if (ml_hold > 0) ml_hold--;
                else if ($urandom_range(0, 24) == 0) ml_hold = $urandom_range(1, 4);
                if (mr_hold > 0) mr_hold--;
                else if ($urandom_range(0, 24) == 0) mr_hold = $urandom_range(1, 4);
                ml = (ml_hold > 0);
                mr = (mr_hold > 0);
                ph = ($urandom_range(0, 3) == 0);
                cyc(st, tk, ml, mr, ph);
            end
        end
        cyc(0, 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
